// File: rtl/norm_unit_pkg.sv
// Shared definitions for the normalizer: operation modes, FSM states and
// the counter width for the default operand size.
package norm_unit_pkg;

    // Normalization operations selected by the 2-bit mode input
    typedef enum logic [1:0] {
        NORM_LZ = 2'b00,  // count leading zeros, shift left
        NORM_TZ = 2'b01,  // count trailing zeros, shift right logical
        NORM_LS = 2'b10   // count redundant sign bits, shift left
    } norm_mode_e;

    // Control states of the normalizer
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } norm_state_e;

    localparam int NORM_WIDTH = 32;
    localparam int CNT_W      = $clog2(NORM_WIDTH) + 1;

    // Map the raw mode field onto an operation; the unused code 11 behaves as LZ
    function automatic norm_mode_e norm_decode_mode(input logic [1:0] m);
        norm_mode_e r;
        case (m)
            2'b01:   r = NORM_TZ;
            2'b10:   r = NORM_LS;
            default: r = NORM_LZ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/norm_unit_step.sv
// One normalization step: decides whether the working operand is already
// normalized for the current mode and, if not, produces it shifted by one.
module norm_step
    import norm_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] sreg_i,
    input  norm_mode_e       mode_i,
    output logic             stop_o,
    output logic [WIDTH-1:0] next_o
);

    // Stop test and single-bit shift for the selected mode
    always_comb begin
        stop_o = 1'b0;
        next_o = sreg_i;
        case (mode_i)
            NORM_LZ: begin
                stop_o = sreg_i[WIDTH-1];
                next_o = {sreg_i[WIDTH-2:0], 1'b0};
            end
            NORM_TZ: begin
                stop_o = sreg_i[0];
                next_o = {1'b0, sreg_i[WIDTH-1:1]};
            end
            NORM_LS: begin
                // normalized once the sign bit differs from the bit below it
                stop_o = sreg_i[WIDTH-1] ^ sreg_i[WIDTH-2];
                next_o = {sreg_i[WIDTH-2:0], 1'b0};
            end
            default: begin
                stop_o = sreg_i[WIDTH-1];
                next_o = {sreg_i[WIDTH-2:0], 1'b0};
            end
        endcase
    end

endmodule

// File: rtl/norm_unit.sv
// Multi-cycle normalizer (CLZ / CTZ / CLS) behind valid/ready handshakes.
// Shifts the operand one bit per cycle until normalized; zero and
// all-ones-sign operands are resolved immediately at accept time.
module norm_unit
    import norm_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [1:0]                 mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           res,
    output logic [$clog2(WIDTH):0]     cnt,
    output logic                       zero
);

    localparam int CNT_BITS = $clog2(WIDTH) + 1;
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(WIDTH);
    localparam logic [CNT_BITS-1:0] CNT_SIGN = CNT_BITS'(WIDTH - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [WIDTH-1:0]    MSB_ONE  = {1'b1, {(WIDTH-1){1'b0}}};

    norm_state_e         state_q;
    norm_mode_e          mode_q;
    norm_mode_e          mode_in_s;
    logic [WIDTH-1:0]    sreg_q;
    logic [WIDTH-1:0]    sreg_d;
    logic                stop_s;
    logic [CNT_BITS-1:0] cnt_q;
    logic [WIDTH-1:0]    res_q;
    logic                zero_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                a_zero_s;
    logic                a_ones_s;

    // Decode the incoming mode and classify the incoming operand for the bypass paths
    always_comb begin
        mode_in_s = norm_decode_mode(mode);
        a_zero_s  = (a == {WIDTH{1'b0}});
        a_ones_s  = (&a);
    end

    norm_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .sreg_i (sreg_q),
        .mode_i (mode_q),
        .stop_o (stop_s),
        .next_o (sreg_d)
    );

    // Control FSM with working register, shift counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= NORM_LZ;
            sreg_q      <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_BITS{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mode_q     <= mode_in_s;
                        sreg_q     <= a;
                        cnt_q      <= {CNT_BITS{1'b0}};
                        in_ready_q <= 1'b0;
                        if (a_zero_s) begin
                            // nothing to normalize; LS counts all but the sign bit
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            res_q       <= {WIDTH{1'b0}};
                            zero_q      <= 1'b1;
                            cnt_q       <= (mode_in_s == NORM_LS) ? CNT_SIGN : CNT_FULL;
                        end else if ((mode_in_s == NORM_LS) && a_ones_s) begin
                            // -1 never shows a sign transition, so resolve it here
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            res_q       <= MSB_ONE;
                            zero_q      <= 1'b0;
                            cnt_q       <= CNT_SIGN;
                        end else begin
                            state_q <= S_RUN;
                            zero_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (stop_s) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        res_q       <= sreg_q;
                    end else begin
                        sreg_q <= sreg_d;
                        cnt_q  <= cnt_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    // results stay frozen until the consumer takes them
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign cnt       = cnt_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_norm_unit.sv
// Self-checking bench for norm_unit: directed cases, backpressure, reset
// abort and randomized operands against a count-based reference model.
module tb_norm_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic [5:0]  cnt;
    logic        zero;

    int total = 0;
    int bad   = 0;

    norm_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .cnt       (cnt),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: number of shifts needed, counted straight from the operand bits
    function automatic int ref_cnt(input logic [31:0] v, input logic [1:0] m);
        int n;
        n = 0;
        if (m == 2'b01) begin
            while (n < 32 && v[n] == 1'b0) n++;
        end else if (m == 2'b10) begin
            while (n < 31 && v[30-n] == v[31]) n++;
        end else begin
            while (n < 32 && v[31-n] == 1'b0) n++;
        end
        return n;
    endfunction

    task automatic do_op(input logic [31:0] av, input logic [1:0] mv, input int bp);
        int          n;
        int          lat;
        int          exp_lat;
        logic [31:0] exp_res;
        logic        exp_zero;
        n        = ref_cnt(av, mv);
        exp_res  = (mv == 2'b01) ? (av >> n) : (av << n);
        exp_zero = (av == 32'h0);
        exp_lat  = (exp_zero || (mv == 2'b10 && av == 32'hFFFF_FFFF)) ? 1 : n + 2;

        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'(1'b1));
        a         = av;
        mode      = mv;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        mode     = 2'($urandom);
        lat      = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        check("latency", 64'(lat), 64'(exp_lat));
        check("res", 64'(res), 64'(exp_res));
        check("cnt", 64'(cnt), 64'(n));
        check("zero", 64'(zero), 64'(exp_zero));
        check("in_ready_busy", 64'(in_ready), 64'(1'b0));
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'($urandom);
            a        = $urandom;
            mode     = 2'($urandom);
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'(1'b1));
            check("hold_ready", 64'(in_ready), 64'(1'b0));
            check("hold_res", 64'(res), 64'(exp_res));
            check("hold_cnt", 64'(cnt), 64'(n));
            check("hold_zero", 64'(zero), 64'(exp_zero));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", 64'(out_valid), 64'(1'b0));
        check("release_ready", 64'(in_ready), 64'(1'b1));
    endtask

    initial begin
        logic [31:0] v;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 32'h0;
        mode      = 2'b00;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(1'b1));
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_res", 64'(res), 64'(32'h0));
        check("rst_cnt", 64'(cnt), 64'(6'd0));
        check("rst_zero", 64'(zero), 64'(1'b0));

        // directed cases
        do_op(32'h0001_0000, 2'b00, 0);
        do_op(32'h0000_0100, 2'b01, 0);
        do_op(32'h8000_0000, 2'b00, 0);
        do_op(32'hFFFF_8000, 2'b10, 0);
        do_op(32'hFFFF_FFFF, 2'b10, 0);
        do_op(32'h0000_0000, 2'b00, 0);
        do_op(32'h0000_0000, 2'b01, 0);
        do_op(32'h0000_0000, 2'b10, 0);
        do_op(32'h0000_0000, 2'b11, 0);
        do_op(32'h0000_0001, 2'b00, 0);
        do_op(32'h0000_0030, 2'b11, 0);
        do_op(32'h7FFF_FFFF, 2'b10, 0);
        do_op(32'h0000_0001, 2'b10, 0);
        do_op(32'h8000_0000, 2'b01, 0);
        do_op(32'hFFFF_FFFF, 2'b00, 0);

        // backpressure then a normal request
        do_op(32'h0040_0000, 2'b00, 5);
        do_op(32'h00F0_0000, 2'b01, 0);

        // reset in the middle of a long run
        @(negedge clk);
        a        = 32'h0000_0001;
        mode     = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'(1'b1));
        check("abort_out_valid", 64'(out_valid), 64'(1'b0));
        check("abort_res", 64'(res), 64'(32'h0));
        check("abort_cnt", 64'(cnt), 64'(6'd0));
        check("abort_zero", 64'(zero), 64'(1'b0));
        repeat (30) @(negedge clk);
        check("abort_no_valid", 64'(out_valid), 64'(1'b0));
        do_op(32'h0000_0001, 2'b00, 0);

        // randomized operands of assorted shapes
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom >> $urandom_range(0, 31);
                1:       v = $urandom << $urandom_range(0, 31);
                2:       v = ~($urandom >> $urandom_range(0, 31));
                default: v = 32'h1 << $urandom_range(0, 31);
            endcase
            do_op(v, 2'($urandom), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
